// File: rtl/neuron_lanes_pkg.sv
// Shared types and constants for the lane-parallel neuron datapath and its activation stage.
// Optional build macro NEURON_SATURATE_EN is consumed by neuron_activation.
package neuron_lanes_pkg;

    typedef enum logic [1:0] {
        NONE,
        RELU,
        LEAKY_RELU
    } activation_type;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ACTIVATE,
        DONE
    } neuron_state_t;

    localparam int INTEGER_WIDTH  = 8;
    localparam int FRACTION_WIDTH = 8;
    localparam int LEAKY_SHIFT    = 3;

    // Sum of num_inputs Q(2I.2F) products plus a shifted bias, with one spare sign bit.
    function automatic int acc_width(input int num_inputs, input int w);
        return 2 * w + $clog2(num_inputs + 1) + 1;
    endfunction

endpackage

// File: rtl/neuron_activation.sv
// Combinational result stage: rescale accumulator, narrow to W (saturating when
// NEURON_SATURATE_EN is defined, wrapping otherwise), then apply the activation.
module neuron_activation
    import neuron_lanes_pkg::*;
#(
    parameter int             W          = 16,
    parameter int             AW         = 40,
    parameter int             FRAC_W     = 8,
    parameter activation_type ACTIVATION = RELU
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [W-1:0]  y
);

    logic signed [AW-1:0] shifted;
    logic signed [W-1:0]  narrowed;

    assign shifted = acc >>> FRAC_W;

`ifdef NEURON_SATURATE_EN
    localparam logic signed [AW-1:0] MAX_V = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    always_comb begin
        if (shifted > MAX_V) begin
            narrowed = {1'b0, {(W-1){1'b1}}};
        end else if (shifted < MIN_V) begin
            narrowed = {1'b1, {(W-1){1'b0}}};
        end else begin
            narrowed = shifted[W-1:0];
        end
    end
`else
    logic unused_high;

    assign narrowed    = shifted[W-1:0];
    assign unused_high = ^shifted[AW-1:W];
`endif

    always_comb begin
        y = narrowed;
        case (ACTIVATION)
            RELU: begin
                if (narrowed[W-1]) y = '0;
            end
            LEAKY_RELU: begin
                if (narrowed[W-1]) y = narrowed >>> LEAKY_SHIFT;
            end
            default: y = narrowed;
        endcase
    end

endmodule

// File: rtl/neuron_lanes.sv
// Neuron computing act(bias + sum inputs*weights), NUM_LANES products per cycle.
// Saturating narrowing is selected with the NEURON_SATURATE_EN macro (see neuron_activation).
module neuron_lanes
    import neuron_lanes_pkg::*;
#(
    parameter int             NUM_INPUTS     = 120,
    parameter int             NUM_LANES      = 8,
    parameter int             INTEGER_WIDTH  = neuron_lanes_pkg::INTEGER_WIDTH,
    parameter int             FRACTION_WIDTH = neuron_lanes_pkg::FRACTION_WIDTH,
    parameter activation_type ACTIVATION     = RELU
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            inputs_ready,
    input  logic signed [INTEGER_WIDTH+FRACTION_WIDTH-1:0]  inputs  [NUM_INPUTS],
    input  logic signed [INTEGER_WIDTH+FRACTION_WIDTH-1:0]  weights [NUM_INPUTS],
    input  logic signed [INTEGER_WIDTH+FRACTION_WIDTH-1:0]  bias,
    output logic                                            busy,
    output logic signed [INTEGER_WIDTH+FRACTION_WIDTH-1:0]  out,
    output logic                                            output_ready
);

    localparam int W  = INTEGER_WIDTH + FRACTION_WIDTH;
    localparam int C  = (NUM_INPUTS + NUM_LANES - 1) / NUM_LANES;
    localparam int AW = acc_width(NUM_INPUTS, W);
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(C - 1);

    neuron_state_t        state_q, state_d;
    logic [CW-1:0]        chunk_q, chunk_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [W-1:0]  out_q, out_d;
    logic                 ready_q, ready_d;

    logic signed [W-1:0]   in_pad [C][NUM_LANES];
    logic signed [W-1:0]   wt_pad [C][NUM_LANES];
    logic signed [2*W-1:0] product;
    logic signed [AW-1:0]  chunk_sum;
    logic signed [W-1:0]   act_out;

    // Reshape into chunk rows; lanes past NUM_INPUTS in the last row read as zero.
    for (genvar c = 0; c < C; c++) begin : g_chunk
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            if (c * NUM_LANES + l < NUM_INPUTS) begin : g_live
                assign in_pad[c][l] = inputs[c*NUM_LANES+l];
                assign wt_pad[c][l] = weights[c*NUM_LANES+l];
            end else begin : g_tail
                assign in_pad[c][l] = '0;
                assign wt_pad[c][l] = '0;
            end
        end
    end

    always_comb begin
        product   = '0;
        chunk_sum = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            product   = (2*W)'(in_pad[chunk_q][l]) * (2*W)'(wt_pad[chunk_q][l]);
            chunk_sum = chunk_sum + AW'(product);
        end
    end

    neuron_activation #(
        .W          (W),
        .AW         (AW),
        .FRAC_W     (FRACTION_WIDTH),
        .ACTIVATION (ACTIVATION)
    ) u_activation (
        .acc (acc_q),
        .y   (act_out)
    );

    // IDLE wait for start | ACCUM add one chunk per edge | ACTIVATE register out | DONE hold until start drops
    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        acc_d   = acc_q;
        out_d   = out_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (inputs_ready) begin
                    state_d = ACCUM;
                    chunk_d = '0;
                    acc_d   = AW'(bias) <<< FRACTION_WIDTH;
                end
            end
            ACCUM: begin
                acc_d = acc_q + chunk_sum;
                if (chunk_q == LAST_CHUNK) begin
                    state_d = ACTIVATE;
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end
            ACTIVATE: begin
                out_d   = act_out;
                ready_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!inputs_ready) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            chunk_q <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            ready_q <= ready_d;
        end
    end

    assign busy         = (state_q == ACCUM) || (state_q == ACTIVATE);
    assign out          = out_q;
    assign output_ready = ready_q;

endmodule

// File: tb/tb_neuron_lanes.sv
// Directed bench for neuron_lanes: four instances (RELU/LEAKY/NONE at 120x8, NONE at 20x8)
// checked against hand-computed Q8.8 results.
module tb_neuron_lanes;
    import neuron_lanes_pkg::*;

    localparam int W  = INTEGER_WIDTH + FRACTION_WIDTH;
    localparam int N  = 120;
    localparam int NS = 20;

    logic clock = 1'b0;
    logic reset;
    logic start_a, start_s;

    logic signed [W-1:0] in_a [N];
    logic signed [W-1:0] wt_a [N];
    logic signed [W-1:0] bias_a;
    logic signed [W-1:0] in_s [NS];
    logic signed [W-1:0] wt_s [NS];
    logic signed [W-1:0] bias_s;

    logic                busy_r, busy_l, busy_n, busy_s;
    logic                rdy_r, rdy_l, rdy_n, rdy_s;
    logic signed [W-1:0] out_r, out_l, out_n, out_s;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    neuron_lanes #(.NUM_INPUTS(N), .NUM_LANES(8), .ACTIVATION(RELU)) u_relu (
        .clock(clock), .reset(reset), .inputs_ready(start_a), .inputs(in_a), .weights(wt_a),
        .bias(bias_a), .busy(busy_r), .out(out_r), .output_ready(rdy_r));

    neuron_lanes #(.NUM_INPUTS(N), .NUM_LANES(8), .ACTIVATION(LEAKY_RELU)) u_leaky (
        .clock(clock), .reset(reset), .inputs_ready(start_a), .inputs(in_a), .weights(wt_a),
        .bias(bias_a), .busy(busy_l), .out(out_l), .output_ready(rdy_l));

    neuron_lanes #(.NUM_INPUTS(N), .NUM_LANES(8), .ACTIVATION(NONE)) u_none (
        .clock(clock), .reset(reset), .inputs_ready(start_a), .inputs(in_a), .weights(wt_a),
        .bias(bias_a), .busy(busy_n), .out(out_n), .output_ready(rdy_n));

    neuron_lanes #(.NUM_INPUTS(NS), .NUM_LANES(8), .ACTIVATION(NONE)) u_small (
        .clock(clock), .reset(reset), .inputs_ready(start_s), .inputs(in_s), .weights(wt_s),
        .bias(bias_s), .busy(busy_s), .out(out_s), .output_ready(rdy_s));

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input logic [W-1:0] x, input logic [W-1:0] w, input logic [W-1:0] b);
        for (int i = 0; i < N; i++) begin
            in_a[i] = x;
            wt_a[i] = w;
        end
        bias_a = b;
    endtask

    task automatic set_s(input logic [W-1:0] x, input logic [W-1:0] w, input logic [W-1:0] b);
        for (int i = 0; i < NS; i++) begin
            in_s[i] = x;
            wt_s[i] = w;
        end
        bias_s = b;
    endtask

    // Raise start, accept at edge k, return edges from k until u_relu reports ready.
    task automatic run_a(output int lat);
        start_a = 1'b1;
        lat = 0;
        tick();
        while (!rdy_r && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic end_a;
        start_a = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset   = 1'b0;
        start_a = 1'b0;
        start_s = 1'b0;
        set_a('0, '0, '0);
        set_s('0, '0, '0);
        tick();
        tick();
        checks++;
        if ({rdy_r, busy_r, out_r} !== {1'b1 ^ 1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_relu got rdy=%b busy=%b out=%h expected 0 0 0000", rdy_r, busy_r, out_r);
        end
        checks++;
        if ({rdy_s, busy_s, out_s} !== {1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_small got rdy=%b busy=%b out=%h expected 0 0 0000", rdy_s, busy_s, out_s);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_relu_latency;
        set_a(16'h0300, 16'h0040, 16'h0000);
        start_a = 1'b1;
        tick();
        for (int j = 0; j < 16; j++) begin
            checks++;
            if ({busy_r, rdy_r} !== 2'b10) begin
                errors++;
                $display("FAIL busy_window edge k+%0d got busy=%b rdy=%b expected 1 0", j, busy_r, rdy_r);
            end
            tick();
        end
        checks++;
        if ({rdy_r, busy_r} !== 2'b10) begin
            errors++;
            $display("FAIL latency_16 got rdy=%b busy=%b expected 1 0", rdy_r, busy_r);
        end
        checks++;
        if (out_r !== 16'h5A00) begin
            errors++;
            $display("FAIL relu_pos got %h expected 5a00", out_r);
        end
        checks++;
        if (out_l !== 16'h5A00) begin
            errors++;
            $display("FAIL leaky_pos got %h expected 5a00", out_l);
        end
        end_a();
        checks++;
        if (rdy_r !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop got %b expected 0", rdy_r);
        end
    endtask

    task automatic test_negative;
        int lat;
        set_a(16'h0300, 16'hFFC0, 16'h0000);
        run_a(lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL neg_latency got %0d expected 16", lat);
        end
        checks++;
        if (out_r !== 16'h0000) begin
            errors++;
            $display("FAIL relu_neg got %h expected 0000", out_r);
        end
        checks++;
        if (out_l !== 16'hF4C0) begin
            errors++;
            $display("FAIL leaky_neg got %h expected f4c0", out_l);
        end
        checks++;
        if (out_n !== 16'hA600) begin
            errors++;
            $display("FAIL none_neg got %h expected a600", out_n);
        end
        end_a();
    endtask

    task automatic test_tail_chunk;
        set_s(16'h0100, 16'h0100, 16'h0280);
        start_s = 1'b1;
        tick();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if ({busy_s, rdy_s} !== 2'b10) begin
                errors++;
                $display("FAIL small_window edge k+%0d got busy=%b rdy=%b expected 1 0", j, busy_s, rdy_s);
            end
            tick();
        end
        checks++;
        if (rdy_s !== 1'b1) begin
            errors++;
            $display("FAIL small_latency got rdy=%b expected 1", rdy_s);
        end
        checks++;
        if (out_s !== 16'h1680) begin
            errors++;
            $display("FAIL small_sum got %h expected 1680", out_s);
        end
        start_s = 1'b0;
        tick();
    endtask

    task automatic test_overflow;
        int lat;
        logic [W-1:0] exp_v;
`ifdef NEURON_SATURATE_EN
        exp_v = 16'h7FFF;
`else
        exp_v = 16'h6800;
`endif
        set_a(16'h0300, 16'h0100, 16'h0000);
        run_a(lat);
        checks++;
        if (out_n !== exp_v) begin
            errors++;
            $display("FAIL overflow_none got %h expected %h", out_n, exp_v);
        end
        checks++;
        if (out_r !== exp_v) begin
            errors++;
            $display("FAIL overflow_relu got %h expected %h", out_r, exp_v);
        end
        end_a();
    endtask

    task automatic test_reset_midjob;
        int lat;
        set_a(16'h0300, 16'h0040, 16'h0000);
        start_a = 1'b1;
        tick();
        for (int j = 0; j < 4; j++) tick();
        reset   = 1'b0;
        start_a = 1'b0;
        #1;
        checks++;
        if ({rdy_r, busy_r, out_r} !== {1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL midjob_reset got rdy=%b busy=%b out=%h expected 0 0 0000", rdy_r, busy_r, out_r);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        run_a(lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL restart_latency got %0d expected 16", lat);
        end
        checks++;
        if (out_r !== 16'h5A00) begin
            errors++;
            $display("FAIL restart_out got %h expected 5a00", out_r);
        end
        end_a();
    endtask

    task automatic test_hold_done;
        int lat;
        set_a(16'h0300, 16'h0040, 16'h0000);
        run_a(lat);
        for (int j = 0; j < 10; j++) begin
            tick();
            checks++;
            if ({rdy_r, busy_r, out_r} !== {1'b1, 1'b0, 16'h5A00}) begin
                errors++;
                $display("FAIL hold_done cycle %0d got rdy=%b busy=%b out=%h expected 1 0 5a00", j, rdy_r, busy_r, out_r);
            end
        end
        end_a();
        checks++;
        if (rdy_r !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got %b expected 0", rdy_r);
        end
        bias_a = 16'h0100;
        run_a(lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL rerun_latency got %0d expected 16", lat);
        end
        checks++;
        if (out_r !== 16'h5B00) begin
            errors++;
            $display("FAIL rerun_out got %h expected 5b00", out_r);
        end
        end_a();
    endtask

    initial begin
        test_reset();
        test_relu_latency();
        test_negative();
        test_tail_chunk();
        test_overflow();
        test_reset_midjob();
        test_hold_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_lanes.md
Name: neuron_lanes

Overview:
Parametrised successor to the single-neuron datapath. It computes out = act(bias + Σ inputs[i]·weights[i]) in signed fixed point Q(INTEGER_WIDTH.FRACTION_WIDTH). NUM_LANES products are accumulated per cycle over ceil(NUM_INPUTS/NUM_LANES) chunks, so a layer can trade multipliers for latency. It sits inside layer instances, one per neuron, driven by the layer's inputs_ready/output_ready handshake.

Parameters:
NUM_INPUTS, 120, number of input/weight pairs (≥1)
NUM_LANES, 8, multipliers used per cycle (1..NUM_INPUTS)
INTEGER_WIDTH, package INTEGER_WIDTH, integer bits incl. sign
FRACTION_WIDTH, package FRACTION_WIDTH, fraction bits
ACTIVATION, RELU, activation_type: NONE, RELU or LEAKY_RELU

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (low = reset asserted)
inputs_ready  in  1  inputs/weights/bias valid; start request
inputs  in  [NUM_INPUTS] x W  signed Q inputs, W = INTEGER_WIDTH+FRACTION_WIDTH
weights  in  [NUM_INPUTS] x W  signed Q weights
bias  in  W  signed Q bias
busy  out  1  high in ACCUM or ACTIVATE
out  out  W  signed Q result, registered
output_ready  out  1  result valid

Behaviour:
- Reset (reset low, asynchronous): state IDLE, chunk counter 0, accumulator 0, out 0, output_ready 0, busy 0. Applies in any state, mid-job included; no partial result survives.
- States: IDLE, ACCUM, ACTIVATE, DONE.
- IDLE: inputs_ready high at edge k -> ACCUM; acc <= bias << FRACTION_WIDTH (sign-extended); chunk <= 0.
- ACCUM: each edge adds lanes chunk*NUM_LANES .. +NUM_LANES-1. Lanes with index ≥ NUM_INPUTS contribute 0 (tail mask). The last chunk (C-1, C = ceil(NUM_INPUTS/NUM_LANES)) moves the FSM to ACTIVATE. Chunks are accumulated at edges k+1..k+C.
- ACTIVATE: edge k+C+1 registers out, sets output_ready=1 and moves to DONE. Latency from the accepting edge is C+1 cycles: 16 at defaults.
- DONE: out and output_ready hold. The FSM stays in DONE while inputs_ready is high (no re-fire). When inputs_ready is low at an edge: output_ready <= 0, IDLE. A new start needs inputs_ready low for ≥1 edge.
- inputs_ready is ignored outside IDLE/DONE. inputs, weights and bias must be held stable from the accepting edge to output_ready; the block does not latch them.
- Arithmetic:
  - Each product is 2W bits, Q(2I.2F).
  - Accumulator width is 2W + clog2(NUM_INPUTS+1) + 1 and never overflows.
  - Result: acc >>> FRACTION_WIDTH (arithmetic shift, floor), then narrowed to W.
- Activation, applied after narrowing:
  - NONE: passes the value through.
  - RELU: negative -> 0.
  - LEAKY_RELU: negative -> value >>> 3.

Optional Feature:
NEURON_SATURATE_EN.
- Defined: narrowing clamps to [-2^(W-1), 2^(W-1)-1].
- Undefined: narrowing keeps the low W bits (two's-complement wrap).
- Activation is applied after narrowing in both cases.

Decomposition:
- Shared package (include.svh) holds:
  - activation_type, extended with NONE and LEAKY_RELU
  - INTEGER_WIDTH and FRACTION_WIDTH defaults
  - neuron_state_t enum
  - function acc_width(num_inputs, w)
  - LEAKY_SHIFT = 3
- Natural sub-module: neuron_activation. It is combinational: narrowing/saturation plus activation on the shifted accumulator, and is reused by future layer-output logic.

Test Plan (INTEGER_WIDTH=8, FRACTION_WIDTH=8 unless noted):
1. NUM_INPUTS=120, NUM_LANES=8, RELU; inputs 3.0, weights 0.25, bias 0; inputs_ready at edge k -> output_ready rises at edge k+16, out=0x5A00 (90.0), busy high edges k+1..k+16.
2. As 1 but weights -0.25 -> RELU: out=0x0000. LEAKY_RELU: out=0xF4C0 (-11.25).
3. NUM_INPUTS=20, NUM_LANES=8, NONE; inputs 1.0, weights 1.0, bias 2.5 -> C=3, output_ready at k+4, out=0x1680 (22.5).
4. Defaults, NONE; inputs 3.0, weights 1.0, bias 0 (sum 360.0):
   - with NEURON_SATURATE_EN -> out=0x7FFF
   - without -> out=0x6800 (104.0)
5. Start job, assert reset low at edge k+5 for 2 cycles -> out=0, output_ready=0, busy=0 immediately. Restart with test-1 stimulus -> out=0x5A00 at start+16.
6. Hold inputs_ready high 10 cycles after output_ready -> output_ready stays 1, out unchanged, busy 0. Drop 1 cycle, change bias to 1.0, raise -> new out=0x5B00 (91.0) after 16 cycles.
